// File: rtl/rsa_lcl_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_lcl_sequencer_pkg
// Description : Shared types and sizing for the RSA local-bus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_lcl_sequencer_pkg;

  localparam int BEAT_W      = 512;
  localparam int N_IN_BEATS  = 6;
  localparam int N_OUT_BEATS = 2;
  localparam int BEAT_CNT_W  = 3;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAP1  = 3'd3,
    ST_ACK   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_CRST  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_lcl_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rsa_lcl_sequencer_if
// Description : Job stream, RSA core side and result stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rsa_lcl_sequencer_if;
  import rsa_lcl_sequencer_pkg::*;

  logic  start;
  logic  busy;
  logic  err;
  beat_t in_data;
  logic  in_valid;
  logic  in_ready;
  beat_t lcl_dout;
  logic  lcl_dv;
  beat_t lcl_din;
  logic  lcl_den;
  logic  lcl_idone;
  beat_t res_data;
  logic  res_valid;
  logic  res_ready;
  logic  res_last;
  logic  core_rst_n;

  // Sequencer side
  modport slave (
    input  start, in_data, in_valid, lcl_din, lcl_den, res_ready,
    output busy, err, in_ready, lcl_dout, lcl_dv, lcl_idone,
           res_data, res_valid, res_last, core_rst_n
  );

  // Environment side (job source, RSA core, result sink)
  modport master (
    output start, in_data, in_valid, lcl_din, lcl_den, res_ready,
    input  busy, err, in_ready, lcl_dout, lcl_dv, lcl_idone,
           res_data, res_valid, res_last, core_rst_n
  );

endinterface
`default_nettype wire

// File: rtl/rsa_lcl_sequencer_res_buf.sv
`default_nettype none
// ============================================================================
// Module      : rsa_res_buf
// Description : Result capture registers with a valid/ready read stream.
//               Slots are written by index; a read burst presents slot 0
//               upward and flags the final slot with last.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_res_buf
  import rsa_lcl_sequencer_pkg::*;
(
  input  wire   clk,
  input  wire   rst_n,
  input  wire   cap_en_i,
  input  wire   cap_sel_i,
  input  beat_t cap_data_i,
  input  wire   rd_start_i,
  input  wire   rd_ready_i,
  output beat_t rd_data_o,
  output logic  rd_valid_o,
  output logic  rd_last_o,
  output logic  rd_done_o
);

  localparam int IDX_W = (N_OUT_BEATS > 1) ? $clog2(N_OUT_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT_BEATS - 1);

  beat_t            buf_q [N_OUT_BEATS];
  logic             rd_valid_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] w_cap_idx;

  assign w_cap_idx = IDX_W'(cap_sel_i);

  for (genvar gi = 0; gi < N_OUT_BEATS; gi++) begin : g_slot
    // Capture one result beat into this slot when addressed
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        buf_q[gi] <= '0;
      end else if (cap_en_i && (w_cap_idx == IDX_W'(gi))) begin
        buf_q[gi] <= cap_data_i;
      end
    end
  end

  // Read burst: start at slot 0, advance on each handshake, stop after last
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else if (rd_start_i) begin
      rd_valid_q <= 1'b1;
      rd_idx_q   <= '0;
    end else if (rd_valid_q && rd_ready_i) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_valid_q <= 1'b0;
        rd_idx_q   <= '0;
      end else begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
    end
  end

  // Data is forced to zero outside a burst so stale results never leak out
  assign rd_data_o  = rd_valid_q ? buf_q[rd_idx_q] : '0;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_valid_q && (rd_idx_q == LAST_IDX);
  assign rd_done_o  = rd_valid_q && rd_ready_i && (rd_idx_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/rsa_lcl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rsa_lcl_sequencer
// Description : Streams a six-beat RSA job to the core, waits (bounded) for
//               the two-beat result, acknowledges it, drains it on the result
//               stream and finally pulses the core reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_lcl_sequencer
  import rsa_lcl_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65536,
  parameter int RST_CYC     = 2
) (
  input wire                  clk,
  input wire                  rst_n,
  rsa_lcl_sequencer_if.slave  bus
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RST_W-1:0]      RST_LAST  = RST_W'(RST_CYC - 1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(N_IN_BEATS - 1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX  = BEAT_CNT_W'(N_IN_BEATS);

  state_e                state_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic [RST_W-1:0]      rst_cnt_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  in_ready_q;
  logic                  lcl_dv_q;
  beat_t                 lcl_dout_q;
  logic                  lcl_idone_q;
  logic                  crst_q;

  logic w_cap_en;
  logic w_cap_sel;
  logic w_rd_start;
  logic w_rd_done;

  // Buffer 0 is written on the first lcl_den in WAIT, buffer 1 one cycle later
  assign w_cap_en   = ((state_q == ST_WAIT) && bus.lcl_den) || (state_q == ST_CAP1);
  assign w_cap_sel  = (state_q == ST_CAP1);
  assign w_rd_start = (state_q == ST_ACK);

  rsa_res_buf u_res_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en_i   (w_cap_en),
    .cap_sel_i  (w_cap_sel),
    .cap_data_i (bus.lcl_din),
    .rd_start_i (w_rd_start),
    .rd_ready_i (bus.res_ready),
    .rd_data_o  (bus.res_data),
    .rd_valid_o (bus.res_valid),
    .rd_last_o  (bus.res_last),
    .rd_done_o  (w_rd_done)
  );

  // Job sequencing FSM; every output it drives is registered here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      lcl_dv_q    <= 1'b0;
      lcl_dout_q  <= '0;
      lcl_idone_q <= 1'b0;
      crst_q      <= 1'b0;
    end else begin
      lcl_dv_q    <= 1'b0;
      lcl_idone_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            lcl_dout_q <= bus.in_data;
            lcl_dv_q   <= 1'b1;
            if (beat_cnt_q == BEAT_LAST) begin
              // Final beat: close the input the same edge it is accepted
              beat_cnt_q <= BEAT_MAX;
              in_ready_q <= 1'b0;
              tmo_cnt_q  <= '0;
              state_q    <= ST_WAIT;
            end else if (beat_cnt_q < BEAT_MAX) begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle still wins over the timeout
          if (bus.lcl_den) begin
            state_q <= ST_CAP1;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_q     <= 1'b1;
            crst_q    <= 1'b1;
            rst_cnt_q <= '0;
            state_q   <= ST_CRST;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_CAP1: begin
          lcl_idone_q <= 1'b1;
          state_q     <= ST_ACK;
        end
        ST_ACK: begin
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_rd_done) begin
            crst_q    <= 1'b1;
            rst_cnt_q <= '0;
            state_q   <= ST_CRST;
          end
        end
        ST_CRST: begin
          if (rst_cnt_q == RST_LAST) begin
            crst_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        default: begin
          crst_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.lcl_dv    = lcl_dv_q;
  assign bus.lcl_dout  = lcl_dout_q;
  assign bus.lcl_idone = lcl_idone_q;
  // Core reset follows rst_n directly so it releases on the first cycle out of reset
  assign bus.core_rst_n = rst_n & ~crst_q;

endmodule
`default_nettype wire
